spi_slave: RTL and testbench

- SPI slave (peripheral) endpoint: the responder to the team's spi_master.
- Oversamples sck/nss/mosi on the system clock, deserialises MOSI into parallel words and serialises a preloaded word onto MISO.
- Supports all four CPOL/CPHA modes and back-to-back words within one nss-low frame.
- Sits between an external SPI bus and a local register/FIFO client.

---
 rtl/spi_slave.sv | 210 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI peripheral endpoint: oversamples sck/nss/mosi on clk, deserialises MOSI, serialises a held word on MISO.
// Optional build macro SPI_SLAVE_MISO_TRISTATE_EN releases miso to 1'bz while not selected.
module spi_slave #(
  parameter int   DATA_WIDTH = 8,
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  nss,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int            CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic sck_meta_q, sck_sync_q, sck_hist_q;
  logic nss_meta_q, nss_sync_q, nss_hist_q;
  logic mosi_meta_q, mosi_sync_q, mosi_hist_q;
  logic [1:0] fill_q;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  underrun_q, underrun_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  ready_q, ready_d;
  logic                  arm_q, arm_d;

  logic sel_s, nss_fall_s, lead_s, trail_s, sample_s, shift_s;

  // Two-stage synchronisers plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_q  <= CPOL;
      sck_sync_q  <= CPOL;
      sck_hist_q  <= CPOL;
      nss_meta_q  <= 1'b1;
      nss_sync_q  <= 1'b1;
      nss_hist_q  <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      mosi_hist_q <= 1'b0;
      fill_q      <= 2'b00;
    end else begin
      sck_meta_q  <= sck;
      sck_sync_q  <= sck_meta_q;
      sck_hist_q  <= sck_sync_q;
      nss_meta_q  <= nss;
      nss_sync_q  <= nss_meta_q;
      nss_hist_q  <= nss_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
      mosi_hist_q <= mosi_sync_q;
      fill_q      <= {fill_q[0], 1'b1};
    end
  end

  // arm_q blocks a frame already in progress when reset released; it needs a real nss-high first
  assign sel_s      = arm_q & ~nss_sync_q;
  assign nss_fall_s = sel_s & nss_hist_q;
  assign lead_s     = (sck_hist_q == CPOL) && (sck_sync_q != CPOL);
  assign trail_s    = (sck_hist_q != CPOL) && (sck_sync_q == CPOL);
  assign sample_s   = sel_s & ((CPHA == 1'b1) ? trail_s : lead_s);
  assign shift_s    = sel_s & ((CPHA == 1'b1) ? lead_s : trail_s);

  // Next-state logic for the shift registers, bit counter and holding register
  always_comb begin
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_shift_d = tx_shift_q;
    underrun_d = 1'b0;
    pend_d     = pend_q;
    hold_d     = hold_q;
    ready_d    = ready_q;
    arm_d      = arm_q | (fill_q[1] & nss_sync_q);

    if (!sel_s) begin
      cnt_d      = {CW{1'b0}};
      rx_shift_d = {DATA_WIDTH{1'b0}};
      tx_shift_d = {DATA_WIDTH{1'b0}};
      pend_d     = 1'b0;
    end else begin
      if (CPHA == 1'b0) begin
        // pend_q: boundary reload found the holding register empty; late fill still wins until the next sample
        if (nss_fall_s) begin
          if (!ready_q) begin
            tx_shift_d = hold_q;
            ready_d    = 1'b1;
          end else begin
            tx_shift_d = {DATA_WIDTH{1'b0}};
            underrun_d = 1'b1;
          end
        end else if (pend_q && !ready_q) begin
          tx_shift_d = hold_q;
          ready_d    = 1'b1;
          pend_d     = 1'b0;
        end else if (pend_q && sample_s) begin
          underrun_d = 1'b1;
          pend_d     = 1'b0;
        end else if (shift_s && (cnt_q != {CW{1'b0}})) begin
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
          tx_shift_d = tx_shift_q;
        end
      end else begin
        if (shift_s && (cnt_q == {CW{1'b0}})) begin
          if (!ready_q) begin
            tx_shift_d = hold_q;
            ready_d    = 1'b1;
          end else begin
            tx_shift_d = {DATA_WIDTH{1'b0}};
            underrun_d = 1'b1;
          end
        end else if (shift_s) begin
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
          tx_shift_d = tx_shift_q;
        end
      end

      if (sample_s) begin
        if (cnt_q == LAST) begin
          rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_hist_q};
          rx_valid_d = 1'b1;
          rx_shift_d = {DATA_WIDTH{1'b0}};
          cnt_d      = {CW{1'b0}};
          if (CPHA == 1'b0) begin
            if (!ready_q) begin
              tx_shift_d = hold_q;
              ready_d    = 1'b1;
            end else begin
              tx_shift_d = {DATA_WIDTH{1'b0}};
              pend_d     = 1'b1;
            end
          end else begin
            pend_d = 1'b0;
          end
        end else begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_hist_q};
          cnt_d      = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_d = cnt_q;
      end
    end

    // A transfer only happens with ready_q low, so it never collides with an accept
    if (tx_valid && ready_q) begin
      hold_d  = tx_data;
      ready_d = 1'b0;
    end else begin
      hold_d = hold_q;
    end
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= {CW{1'b0}};
      rx_shift_q <= {DATA_WIDTH{1'b0}};
      rx_data_q  <= {DATA_WIDTH{1'b0}};
      rx_valid_q <= 1'b0;
      tx_shift_q <= {DATA_WIDTH{1'b0}};
      underrun_q <= 1'b0;
      pend_q     <= 1'b0;
      hold_q     <= {DATA_WIDTH{1'b0}};
      ready_q    <= 1'b1;
      arm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      underrun_q <= underrun_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      ready_q    <= ready_d;
      arm_q      <= arm_d;
    end
  end

  assign tx_ready    = ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = sel_s;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = sel_s ? tx_shift_q[DATA_WIDTH-1] : 1'bz;
`else
  assign miso = tx_shift_q[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per CPOL/CPHA mode sharing a bit-banged master.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck_base = 1'b0;
  logic       mosi = 1'b0;
  logic [3:0] nss_v = 4'hF;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] tx_valid_v = 4'h0;
  logic [3:0] miso_v, tx_ready_v, rx_valid_v, underrun_v, busy_v;
  logic [7:0] rx_data_v [4];

  int n_cmp = 0;
  int n_err = 0;
  int rxv_n [4] = '{default: 0};
  int urn_n [4] = '{default: 0};
  logic [7:0] log0 = 8'h00;
  logic [7:0] log1 = 8'h00;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic sck_w;
    assign sck_w = (g >= 2) ? ~sck_base : sck_base;
    spi_slave #(
      .DATA_WIDTH (8),
      .CPOL       ((g >= 2) ? 1'b1 : 1'b0),
      .CPHA       ((g % 2 == 1) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sck         (sck_w),
      .nss         (nss_v[g]),
      .mosi        (mosi),
      .miso        (miso_v[g]),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid_v[g]),
      .tx_ready    (tx_ready_v[g]),
      .rx_data     (rx_data_v[g]),
      .rx_valid    (rx_valid_v[g]),
      .tx_underrun (underrun_v[g]),
      .busy        (busy_v[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid_v[i]) rxv_n[i] <= rxv_n[i] + 1;
      if (underrun_v[i]) urn_n[i] <= urn_n[i] + 1;
    end
    if (rx_valid_v[0]) begin
      log0 <= rx_data_v[0];
      log1 <= log0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic load_tx(input int m, input logic [7:0] d);
    tx_data = d;
    tx_valid_v[m] = 1'b1;
    @(negedge clk);
    tx_valid_v[m] = 1'b0;
  endtask

  task automatic sel(input int m);
    nss_v[m] = 1'b0;
    half();
  endtask

  task automatic desel(input int m);
    half();
    nss_v[m] = 1'b1;
    half();
  endtask

  task automatic spi_word(input int m, input logic [7:0] mo, input int nb, output logic [7:0] mi);
    mi = 8'h00;
    for (int b = 7; b >= 8 - nb; b--) begin
      if (m % 2 == 0) begin
        mosi = mo[b];
        half();
        mi = {mi[6:0], miso_v[m]};
        sck_base = 1'b1;
        half();
        sck_base = 1'b0;
      end else begin
        sck_base = 1'b1;
        mosi = mo[b];
        half();
        mi = {mi[6:0], miso_v[m]};
        sck_base = 1'b0;
        half();
      end
    end
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int r0, u0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_rx_data", rx_data_v[0], 8'h00);
    chk("rst_tx_ready", tx_ready_v[0], 1'b1);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_miso", miso_v[0], 1'b0);
    chk("rst_rx_valid", rx_valid_v[0], 1'b0);
    chk("rst_underrun", underrun_v[0], 1'b0);

    // Mode 0 single word
    r0 = rxv_n[0]; u0 = urn_n[0];
    load_tx(0, 8'h5A);
    chk("m0_ready_low", tx_ready_v[0], 1'b0);
    sel(0);
    chk("m0_busy", busy_v[0], 1'b1);
    chk("m0_ready_back", tx_ready_v[0], 1'b1);
    spi_word(0, 8'hA5, 8, mi);
    desel(0);
    chk("m0_rx_data", rx_data_v[0], 8'hA5);
    chk("m0_rxv_pulses", rxv_n[0] - r0, 1);
    chk("m0_master_rx", mi, 8'h5A);
    chk("m0_no_underrun", urn_n[0] - u0, 0);
    chk("m0_busy_idle", busy_v[0], 1'b0);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      r0 = rxv_n[m];
      load_tx(m, 8'hC3);
      sel(m);
      spi_word(m, 8'h3C, 8, mi);
      desel(m);
      chk($sformatf("mode%0d_rx_data", m), rx_data_v[m], 8'h3C);
      chk($sformatf("mode%0d_master_rx", m), mi, 8'hC3);
      chk($sformatf("mode%0d_rxv_pulses", m), rxv_n[m] - r0, 1);
      chk($sformatf("mode%0d_miso_idle", m), miso_v[m], 1'b0);
    end

    // Back-to-back words in one frame
    r0 = rxv_n[0]; u0 = urn_n[0];
    load_tx(0, 8'h11);
    nss_v[0] = 1'b0;
    for (int k = 0; k < 50 && !tx_ready_v[0]; k++) @(negedge clk);
    chk("b2b_ready_rise", tx_ready_v[0], 1'b1);
    load_tx(0, 8'h22);
    half();
    spi_word(0, 8'hDE, 8, mi);
    spi_word(0, 8'hAD, 8, mi2);
    desel(0);
    chk("b2b_rxv_pulses", rxv_n[0] - r0, 2);
    chk("b2b_first_rx", log1, 8'hDE);
    chk("b2b_second_rx", log0, 8'hAD);
    chk("b2b_master_rx0", mi, 8'h11);
    chk("b2b_master_rx1", mi2, 8'h22);
    chk("b2b_no_underrun", urn_n[0] - u0, 0);

    // Underrun: nothing preloaded
    r0 = rxv_n[0]; u0 = urn_n[0];
    sel(0);
    chk("urn_at_start", urn_n[0] - u0, 1);
    spi_word(0, 8'hFF, 8, mi);
    desel(0);
    chk("urn_single", urn_n[0] - u0, 1);
    chk("urn_master_rx", mi, 8'h00);
    chk("urn_rx_data", rx_data_v[0], 8'hFF);
    chk("urn_rxv_pulses", rxv_n[0] - r0, 1);

    // Abort after 5 bits, then a clean frame
    r0 = rxv_n[0];
    sel(0);
    spi_word(0, 8'hA5, 5, mi);
    desel(0);
    chk("abort_no_rxv", rxv_n[0] - r0, 0);
    chk("abort_rx_kept", rx_data_v[0], 8'hFF);
    chk("abort_miso", miso_v[0], 1'b0);
    sel(0);
    spi_word(0, 8'h96, 8, mi);
    desel(0);
    chk("post_abort_rx", rx_data_v[0], 8'h96);
    chk("post_abort_rxv", rxv_n[0] - r0, 1);

    // Asynchronous reset in the middle of a word
    load_tx(0, 8'h77);
    sel(0);
    spi_word(0, 8'hF0, 3, mi);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("arst_rx_data", rx_data_v[0], 8'h00);
    chk("arst_tx_ready", tx_ready_v[0], 1'b1);
    chk("arst_busy", busy_v[0], 1'b0);
    chk("arst_rx_valid", rx_valid_v[0], 1'b0);
    chk("arst_underrun", underrun_v[0], 1'b0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    chk("arst_miso", miso_v[0], 1'bz);
`else
    chk("arst_miso", miso_v[0], 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rxv_n[0];
    spi_word(0, 8'hF0, 5, mi);
    chk("arst_frame_ignored_busy", busy_v[0], 1'b0);
    desel(0);
    chk("arst_frame_ignored_rxv", rxv_n[0] - r0, 0);
    chk("arst_frame_ignored_rx", rx_data_v[0], 8'h00);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    chk("desel_miso", miso_v[0], 1'bz);
`else
    chk("desel_miso", miso_v[0], 1'b0);
`endif
    sel(0);
    spi_word(0, 8'h81, 8, mi);
    desel(0);
    chk("post_rst_rx", rx_data_v[0], 8'h81);
    chk("post_rst_rxv", rxv_n[0] - r0, 1);
    chk("post_rst_master_rx", mi, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
